// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the player input stage and the character FSM:
//   - attack_state_e : 2-bit attack duty-policy FSM encoding
//   - LEFT / RIGHT   : direction constants used by last-direction tracking
package game_pkg;

  typedef enum logic [1:0] {
    A_READY    = 2'd0,
    A_ACTIVE   = 2'd1,
    A_COOLDOWN = 2'd2,
    A_WAITREL  = 2'd3
  } attack_state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/debounce.sv
// debounce
// Two-flop synchronizer followed by a counter-based debouncer for one raw,
// asynchronous, active-high button.  The debounced level only changes after
// the synchronized input has disagreed with it for DEBOUNCE_CYCLES
// consecutive cycles; any shorter disagreement resets the counter.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles required to accept a change (>= 1)
//   CNT_W           : counter width, must hold DEBOUNCE_CYCLES
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   raw_i  in  raw button level (asynchronous)
//   db_o   out debounced level (registered)
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only advances while the synchronized input disagrees with
  // the accepted level, and it stops at DB_LAST where the change is taken,
  // so it can never wrap.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/player_input.sv
// player_input
// Conditions the raw left/right/attack buttons of one player for the
// character FSM: synchronize + debounce each button, register the direction
// levels, and run an attack duty policy (maximum hold time, cooldown, fresh
// press required).
//
// Optional feature macro: SOCD_LAST_WINS_EN
//   defined   : with both directions held, only the most recently pressed
//               one is output (last_dir flop, reset value LEFT)
//   undefined : left/right simply mirror the debounced levels
//
// Parameters:
//   DEBOUNCE_CYCLES : debounce window in cycles (>= 1)
//   ATTACK_MAX      : maximum attack high time per press (>= 1)
//   COOLDOWN_CYCLES : forced-low time after an attack (>= 1)
//   CNT_W           : counter width; must hold the largest parameter and
//                     also DEBOUNCE_CYCLES+2 (startup settle window)
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   btn_left_raw, btn_right_raw, btn_attack_raw  raw async buttons
//   left, right, attack                      conditioned registered levels
module player_input
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ATTACK_MAX      = 25000000,
  parameter int unsigned COOLDOWN_CYCLES = 12500000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic btn_attack_raw,
  output logic left,
  output logic right,
  output logic attack
);

  localparam logic [CNT_W-1:0] ATK_LAST    = CNT_W'(ATTACK_MAX - 1);
  localparam logic [CNT_W-1:0] CD_LAST     = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES + 2);

  logic db_left;
  logic db_right;
  logic db_attack;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (btn_left_raw),
    .db_o  (db_left)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (btn_right_raw),
    .db_o  (db_right)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_attack (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (btn_attack_raw),
    .db_o  (db_attack)
  );

  // ---------------------------------------------------------------------
  // Direction outputs
  // ---------------------------------------------------------------------
  logic left_q, left_d;
  logic right_q, right_d;

`ifdef SOCD_LAST_WINS_EN
  logic db_left_q;
  logic db_right_q;
  logic last_dir_q, last_dir_d;

  // last_dir_d is used (not last_dir_q) so the newly pressed direction takes
  // over on the same edge it first appears on the outputs.
  always_comb begin
    last_dir_d = last_dir_q;
    if (db_left && !db_left_q) begin
      last_dir_d = LEFT;
    end
    if (db_right && !db_right_q) begin
      last_dir_d = RIGHT;
    end
    left_d  = db_left  && (!db_right || (last_dir_d == LEFT));
    right_d = db_right && (!db_left  || (last_dir_d == RIGHT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_left_q  <= 1'b0;
      db_right_q <= 1'b0;
      last_dir_q <= LEFT;
    end else begin
      db_left_q  <= db_left;
      db_right_q <= db_right;
      last_dir_q <= last_dir_d;
    end
  end
`else
  always_comb begin
    left_d  = db_left;
    right_d = db_right;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // ---------------------------------------------------------------------
  // Attack duty policy
  // ---------------------------------------------------------------------
  attack_state_e    state_q, state_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             db_attack_q;
  logic             armed_q, armed_d;
  logic             attack_q, attack_d;
  logic             press;

  // After reset the debouncer restarts from 0, so a button held through
  // reset would look like a fresh rising edge.  Presses are only accepted
  // once the debounced attack level has been seen low after it had time to
  // settle (2 sync stages + debounce window).
  always_comb begin
    settle_d = (settle_q == SETTLE_LAST) ? settle_q : settle_q + CNT_W'(1);
    armed_d  = armed_q || ((settle_q == SETTLE_LAST) && !db_attack);
  end

  assign press = armed_q && db_attack && !db_attack_q;

  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    unique case (state_q)
      A_READY: begin
        if (press) begin
          state_d = A_ACTIVE;
          acnt_d  = ATK_LAST;
        end
      end
      A_ACTIVE: begin
        // Release and timeout on the same cycle share this single exit.
        if (!db_attack || (acnt_q == '0)) begin
          state_d = A_COOLDOWN;
          acnt_d  = CD_LAST;
        end else begin
          acnt_d = acnt_q - CNT_W'(1);
        end
      end
      A_COOLDOWN: begin
        if (acnt_q == '0) begin
          state_d = db_attack ? A_WAITREL : A_READY;
        end else begin
          acnt_d = acnt_q - CNT_W'(1);
        end
      end
      A_WAITREL: begin
        if (!db_attack) begin
          state_d = A_READY;
        end
      end
      default: begin
        state_d = A_READY;
      end
    endcase
    attack_d = (state_d == A_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= A_READY;
      acnt_q      <= '0;
      settle_q    <= '0;
      db_attack_q <= 1'b0;
      armed_q     <= 1'b0;
      attack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acnt_q      <= acnt_d;
      settle_q    <= settle_d;
      db_attack_q <= db_attack;
      armed_q     <= armed_d;
      attack_q    <= attack_d;
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign attack = attack_q;

endmodule

// File: tb/tb_player_input.sv
// tb_player_input
// Event scoreboard bench for player_input with DEBOUNCE_CYCLES=4,
// ATTACK_MAX=8, COOLDOWN_CYCLES=5, CNT_W=8.  Stimulus pushes the expected
// output transitions (signal, value, cycle) into a queue; the monitor pops
// one entry for every transition it observes on the outputs.
module tb_player_input;

  localparam int SIG_LEFT   = 0;
  localparam int SIG_RIGHT  = 1;
  localparam int SIG_ATTACK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btnLeft = 1'b0;
  logic btnRight = 1'b0;
  logic btnAttack = 1'b0;
  logic leftOut;
  logic rightOut;
  logic attackOut;

  typedef struct {
    int   sig;
    logic val;
    int   cyc;
  } expEvent_t;

  expEvent_t expQ[$];
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;
  logic [2:0] prevOut = 3'b000;
  logic [2:0] curOut;
  string     sigNames [3] = '{"left", "right", "attack"};

  player_input #(
    .DEBOUNCE_CYCLES (4),
    .ATTACK_MAX      (8),
    .COOLDOWN_CYCLES (5),
    .CNT_W           (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_left_raw   (btnLeft),
    .btn_right_raw  (btnRight),
    .btn_attack_raw (btnAttack),
    .left           (leftOut),
    .right          (rightOut),
    .attack         (attackOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic l, input logic r, input logic a);
    btnLeft   = l;
    btnRight  = r;
    btnAttack = a;
  endtask

  task automatic expectEvent(input int sig, input logic val, input int offset);
    expEvent_t e;
    e.sig = sig;
    e.val = val;
    e.cyc = cyc + offset;
    expQ.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input int sig, input logic val);
    expEvent_t e;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_%s: got %s=%0b at cycle %0d, required no change",
               sigNames[sig], sigNames[sig], val, cyc);
    end else begin
      e = expQ.pop_front();
      if (e.sig != sig || e.val !== val || e.cyc != cyc) begin
        failures++;
        $display("[TB] FAIL event_%s: got %s=%0b at cycle %0d, required %s=%0b at cycle %0d",
                 sigNames[e.sig], sigNames[sig], val, cyc, sigNames[e.sig], e.val, e.cyc);
      end
    end
  endtask

  task automatic checkDirect(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  // Monitor: every output transition consumes one scoreboard entry.
  always @(negedge clk) begin
    curOut = {leftOut, rightOut, attackOut};
    for (int i = 0; i < 3; i++) begin
      if (curOut[2-i] !== prevOut[2-i]) begin
        checkOutput(i, curOut[2-i]);
      end
    end
    prevOut = curOut;
  end

  initial begin
    expEvent_t e;

    // Reset with all buttons held; outputs must be cleared.
    applyStimulus(1'b1, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    waitCycles(3);
    checkDirect("reset_left", leftOut, 1'b0);
    checkDirect("reset_right", rightOut, 1'b0);
    checkDirect("reset_attack", attackOut, 1'b0);

    // Release with left held: left appears 7 edges later.
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectEvent(SIG_LEFT, 1'b1, 7);
    waitCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectEvent(SIG_LEFT, 1'b0, 7);
    waitCycles(12);

    // 3-cycle right glitch is filtered; 6-cycle pulse passes unchanged.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectEvent(SIG_RIGHT, 1'b1, 7);
    expectEvent(SIG_RIGHT, 1'b0, 13);
    waitCycles(6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(14);

    // Long hold: attack limited to 8 cycles, then held low until release.
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectEvent(SIG_ATTACK, 1'b1, 7);
    expectEvent(SIG_ATTACK, 1'b0, 15);
    waitCycles(40);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectEvent(SIG_ATTACK, 1'b1, 7);
    expectEvent(SIG_ATTACK, 1'b0, 15);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(15);

    // Short press (4 debounced cycles), re-press landing inside the
    // cooldown is ignored until released; a later press attacks again.
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectEvent(SIG_ATTACK, 1'b1, 7);
    expectEvent(SIG_ATTACK, 1'b0, 11);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(18);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectEvent(SIG_ATTACK, 1'b1, 7);
    expectEvent(SIG_ATTACK, 1'b0, 11);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(15);

    // Reset while attacking drops attack without a clock edge; a button
    // held through reset must be released and pressed again.
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectEvent(SIG_ATTACK, 1'b1, 7);
    waitCycles(10);
    expectEvent(SIG_ATTACK, 1'b0, 1);
    #2 rst_n = 1'b0;
    #1 checkDirect("async_reset_attack", attackOut, 1'b0);
    @(negedge clk);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(12);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectEvent(SIG_ATTACK, 1'b1, 7);
    expectEvent(SIG_ATTACK, 1'b0, 13);
    waitCycles(6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(15);

    // Left held, then right pressed and released.
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectEvent(SIG_LEFT, 1'b1, 7);
    waitCycles(12);
    applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef SOCD_LAST_WINS_EN
    expectEvent(SIG_LEFT, 1'b0, 7);
    expectEvent(SIG_RIGHT, 1'b1, 7);
`else
    expectEvent(SIG_RIGHT, 1'b1, 7);
`endif
    waitCycles(12);
    applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef SOCD_LAST_WINS_EN
    expectEvent(SIG_LEFT, 1'b1, 7);
    expectEvent(SIG_RIGHT, 1'b0, 7);
`else
    expectEvent(SIG_RIGHT, 1'b0, 7);
`endif
    waitCycles(12);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectEvent(SIG_LEFT, 1'b0, 7);
    waitCycles(15);

    // Any expected transition never observed is a failure.
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missing_%s: got no transition, required %s=%0b at cycle %0d",
               sigNames[e.sig], sigNames[e.sig], e.val, e.cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of stimulus, required finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
